// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing plus the shared memory handshake.
// Define CTRL_INSTRET_EN to add the 32-bit retired-instruction counter output instret.
module multicycle_ctrl #(
  parameter bit RESET_TRAP_CLR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_taken,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic [4:0]  imm_sel,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [3:0]  alu_op,
  output logic        alu_out_we,
  output logic        rd_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        retire,
  output logic        illegal
`ifdef CTRL_INSTRET_EN
  ,
  output logic [31:0] instret
`endif
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_JALR, C_LOAD, C_OPIMM,
    C_BRANCH, C_STORE, C_OP, C_FENCE, C_ILL
  } cls_t;

  state_t      state, state_next;
  cls_t        cls;
  logic        br_q;
  logic        held;
  logic [4:0]  imm_dec;
  logic [2:0]  funct3;
  logic        unused_bits;

  assign funct3      = instr[14:12];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
  assign illegal     = (state == TRAP);

  always_comb begin
    cls = C_ILL;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:2])
        5'b01101: cls = C_LUI;
        5'b00101: cls = C_AUIPC;
        5'b11011: cls = C_JAL;
        5'b11001: cls = C_JALR;
        5'b00000: cls = C_LOAD;
        5'b00100: cls = C_OPIMM;
        5'b11000: cls = C_BRANCH;
        5'b01000: cls = C_STORE;
        5'b01100: cls = C_OP;
        5'b00011: cls = C_FENCE;
        default:  cls = C_ILL;
      endcase
    end
  end

  always_comb begin
    imm_dec = 5'b00000;
    case (cls)
      C_JALR, C_LOAD, C_OPIMM: imm_dec = 5'b00001;
      C_STORE:                 imm_dec = 5'b00010;
      C_BRANCH:                imm_dec = 5'b00100;
      C_LUI, C_AUIPC:          imm_dec = 5'b01000;
      C_JAL:                   imm_dec = 5'b10000;
      default:                 imm_dec = 5'b00000;
    endcase
  end

  // held marks that the previous edge sampled rst; a TRAP survives reset only when RESET_TRAP_CLR=0
  always_ff @(posedge clk) begin
    if (rst) begin
      held <= 1'b1;
      br_q <= 1'b0;
      if (RESET_TRAP_CLR || state != TRAP) state <= FETCH;
    end else begin
      held  <= 1'b0;
      state <= state_next;
      if (state == EXEC) br_q <= br_taken;
    end
  end

  always_comb begin
    state_next   = state;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    imm_sel      = 5'b00000;
    alu_a_sel    = 2'd0;
    alu_b_sel    = 1'b0;
    alu_op       = 4'b0000;
    alu_out_we   = 1'b0;
    rd_we        = 1'b0;
    wb_sel       = 2'd0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    retire       = 1'b0;
    case (state)
      FETCH: begin
        // stay quiet while reset is still held after being sampled
        if (!(held && rst)) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_we      = 1'b1;
            state_next = DECODE;
          end
        end
      end
      DECODE: begin
        imm_sel = imm_dec;
        if (cls == C_ILL) begin
          state_next = TRAP;
        end else if (cls == C_FENCE) begin
          pc_we      = 1'b1;
          retire     = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        imm_sel    = imm_dec;
        alu_out_we = 1'b1;
        case (cls)
          C_AUIPC, C_JAL, C_BRANCH: alu_a_sel = 2'd1;
          C_LUI:                    alu_a_sel = 2'd2;
          default:                  alu_a_sel = 2'd0;
        endcase
        alu_b_sel = (cls != C_OP);
        if (cls == C_OP)
          alu_op = {instr[30], funct3};
        else if (cls == C_OPIMM)
          alu_op = {(funct3 == 3'b101) & instr[30], funct3};
        state_next = (cls == C_LOAD || cls == C_STORE) ? MEM : WB;
      end
      MEM: begin
        imm_sel      = imm_dec;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls == C_STORE);
        if (mem_ack) begin
          if (cls == C_STORE) begin
            pc_we      = 1'b1;
            retire     = 1'b1;
            state_next = FETCH;
          end else begin
            state_next = WB;
          end
        end
      end
      WB: begin
        imm_sel    = imm_dec;
        pc_we      = 1'b1;
        retire     = 1'b1;
        rd_we      = (cls != C_BRANCH);
        if (cls == C_LOAD)
          wb_sel = 2'd1;
        else if (cls == C_JAL || cls == C_JALR)
          wb_sel = 2'd2;
        if (cls == C_JAL || cls == C_JALR)
          pc_sel = 1'b1;
        else if (cls == C_BRANCH)
          pc_sel = br_q;
        state_next = FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase
  end

`ifdef CTRL_INSTRET_EN
  always_ff @(posedge clk) begin
    if (rst)
      instret <= 32'd0;
    else if (retire)
      instret <= instret + 32'd1;
  end
`endif

endmodule
